us_timebase: RTL and testbench

//  Consumes the divided reference (~1 MHz square wave) from the clock-divider stage as data in the clk domain.

---
 rtl/us_timebase_pkg.sv | 12 +
 rtl/us_timebase_if.sv | 24 ++
 rtl/us_timebase_edge_sync.sv | 40 ++++
 rtl/us_timebase.sv | 127 ++++++++++++
 tb/tb_us_timebase.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/us_timebase_pkg.sv
// Shared types and defaults for the microsecond timebase.
package timebase_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } tmr_state_t;

   localparam int unsigned TMR_W_DEF     = 16;
   localparam int unsigned US_PER_MS_DEF = 1000;

endpackage

// File: rtl/us_timebase_if.sv
// Timer control/status bundle between a client (master) and the timebase (slave).
interface us_timebase_if #(
   parameter int unsigned TMR_W = timebase_pkg::TMR_W_DEF
);

   logic             tmr_load;
   logic [TMR_W-1:0] tmr_period;
   logic             tmr_periodic;
   logic             tmr_stop;
   logic             tmr_busy;
   logic             tmr_expired;
   logic [TMR_W-1:0] tmr_remaining;

   modport master (
      output tmr_load, tmr_period, tmr_periodic, tmr_stop,
      input  tmr_busy, tmr_expired, tmr_remaining
   );

   modport slave (
      input  tmr_load, tmr_period, tmr_periodic, tmr_stop,
      output tmr_busy, tmr_expired, tmr_remaining
   );

endinterface

// File: rtl/us_timebase_edge_sync.sv
// Brings the divided reference into the clk domain and flags its rising edges.
module edge_sync #(
   parameter bit SYNC_EN = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic freq_in,
   output logic edge_p
);

   generate
      if (SYNC_EN) begin : g_sync
         logic s0, s1, s2;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               s0 <= 1'b0;
               s1 <= 1'b0;
               s2 <= 1'b0;
            end else begin
               s0 <= freq_in;
               s1 <= s0;
               s2 <= s1;
            end
         end

         assign edge_p = s1 & ~s2;
      end else begin : g_nosync
         logic s2;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) s2 <= 1'b0;
            else     s2 <= freq_in;
         end

         assign edge_p = freq_in & ~s2;
      end
   endgenerate

endmodule

// File: rtl/us_timebase.sv
// Microsecond/millisecond strobes, free-running us counter and a loadable us timer,
// all derived from the divided reference sampled as data in the clk domain.
module us_timebase
   import timebase_pkg::*;
#(
   parameter bit          SYNC_EN      = 1'b1,
   parameter int unsigned EDGES_PER_US = 1,
   parameter int unsigned US_PER_MS    = US_PER_MS_DEF,
   parameter int unsigned TMR_W        = TMR_W_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               freq_in,
   us_timebase_if.slave       tmr,
   output logic               tick_us,
   output logic               tick_ms,
   output logic [31:0]        us_count
);

   localparam int unsigned EW = (EDGES_PER_US > 1) ? $clog2(EDGES_PER_US) : 1;
   localparam int unsigned MW = (US_PER_MS > 1) ? $clog2(US_PER_MS) : 1;
   localparam logic [EW-1:0] EDGE_LAST = EW'(EDGES_PER_US - 1);
   localparam logic [MW-1:0] MS_LAST   = MW'(US_PER_MS - 1);

   logic             edge_p;
   logic [EW-1:0]    edge_cnt;
   logic [MW-1:0]    ms_cnt;
   logic [31:0]      us_cnt;
   logic             tick_us_q;
   logic             tick_ms_q;

   tmr_state_t       state;
   logic [TMR_W-1:0] remaining;
   logic [TMR_W-1:0] period_lat;
   logic             periodic_lat;
   logic             busy_q;
   logic             expired_q;

   edge_sync #(.SYNC_EN(SYNC_EN)) u_edge_sync (
      .clk     (clk),
      .rst     (rst),
      .freq_in (freq_in),
      .edge_p  (edge_p)
   );

   // tick_ms and the us_count increment land together with the wrapping tick_us.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         edge_cnt  <= '0;
         ms_cnt    <= '0;
         us_cnt    <= '0;
         tick_us_q <= 1'b0;
         tick_ms_q <= 1'b0;
      end else begin
         tick_us_q <= 1'b0;
         tick_ms_q <= 1'b0;
         if (edge_p) begin
            if (edge_cnt == EDGE_LAST) begin
               edge_cnt  <= '0;
               tick_us_q <= 1'b1;
               us_cnt    <= us_cnt + 32'd1;
               if (ms_cnt == MS_LAST) begin
                  ms_cnt    <= '0;
                  tick_ms_q <= 1'b1;
               end else begin
                  ms_cnt <= ms_cnt + 1'b1;
               end
            end else begin
               edge_cnt <= edge_cnt + 1'b1;
            end
         end
      end
   end

   // Priority: stop, then load, then tick. A zero-period load while running just idles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         remaining    <= '0;
         period_lat   <= '0;
         periodic_lat <= 1'b0;
         busy_q       <= 1'b0;
         expired_q    <= 1'b0;
      end else begin
         expired_q <= 1'b0;
         if (tmr.tmr_stop) begin
            state     <= IDLE;
            remaining <= '0;
            busy_q    <= 1'b0;
         end else if (tmr.tmr_load) begin
            if (tmr.tmr_period == '0) begin
               expired_q <= (state == IDLE);
               state     <= IDLE;
               remaining <= '0;
               busy_q    <= 1'b0;
            end else begin
               state        <= RUN;
               remaining    <= tmr.tmr_period;
               period_lat   <= tmr.tmr_period;
               periodic_lat <= tmr.tmr_periodic;
               busy_q       <= 1'b1;
            end
         end else if (state == RUN && tick_us_q) begin
            if (remaining == TMR_W'(1)) begin
               expired_q <= 1'b1;
               if (periodic_lat) begin
                  remaining <= period_lat;
               end else begin
                  remaining <= '0;
                  state     <= IDLE;
                  busy_q    <= 1'b0;
               end
            end else begin
               remaining <= remaining - 1'b1;
            end
         end
      end
   end

   assign tick_us           = tick_us_q;
   assign tick_ms           = tick_ms_q;
   assign us_count          = us_cnt;
   assign tmr.tmr_busy      = busy_q;
   assign tmr.tmr_expired   = expired_q;
   assign tmr.tmr_remaining = remaining;

endmodule

// File: tb/tb_us_timebase.sv
// Randomized bench for us_timebase checked against a cycle-level behavioural model.
module tb_us_timebase;

   localparam int unsigned U  = 4;
   localparam int unsigned TW = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        freq_in = 1'b0;
   logic        tick_us, tick_ms;
   logic [31:0] us_count;

   us_timebase_if #(.TMR_W(TW)) tif ();

   us_timebase #(
      .SYNC_EN      (1'b1),
      .EDGES_PER_US (1),
      .US_PER_MS    (U),
      .TMR_W        (TW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .freq_in  (freq_in),
      .tmr      (tif.slave),
      .tick_us  (tick_us),
      .tick_ms  (tick_ms),
      .us_count (us_count)
   );

   always #5 clk = ~clk;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Model state: freq_in samples taken at each clk edge, newest first.
   bit          fh[$];
   logic [31:0] m_us;
   bit          m_tick, m_ms, m_run, m_per, m_exp;
   int unsigned m_rem, m_lp;

   task automatic model_reset();
      fh.delete();
      repeat (4) fh.push_front(1'b0);
      m_us = 0; m_tick = 0; m_ms = 0;
      m_run = 0; m_per = 0; m_exp = 0; m_rem = 0; m_lp = 0;
   endtask

   // Spec rules: a rising edge seen in samples k-3 -> k-2 produces tick_us after edge k.
   task automatic model_edge();
      bit tick_prev;
      tick_prev = m_tick;
      fh.push_front(freq_in);
      while (fh.size() > 4) void'(fh.pop_back());
      m_tick = fh[2] & ~fh[3];
      m_ms = 0;
      if (m_tick) begin
         m_us = m_us + 1;
         m_ms = ((m_us % U) == 0);
      end
      m_exp = 0;
      if (tif.tmr_stop) begin
         m_run = 0; m_rem = 0;
      end else if (tif.tmr_load) begin
         if (tif.tmr_period == 0) begin
            if (!m_run) m_exp = 1;
            m_run = 0; m_rem = 0;
         end else begin
            m_rem = tif.tmr_period; m_lp = tif.tmr_period;
            m_per = tif.tmr_periodic; m_run = 1;
         end
      end else if (m_run && tick_prev) begin
         if (m_rem == 1) begin
            m_exp = 1;
            if (m_per) m_rem = m_lp;
            else begin m_rem = 0; m_run = 0; end
         end else begin
            m_rem = m_rem - 1;
         end
      end
   endtask

   task automatic check_all();
      chk("tick_us", 32'(tick_us), 32'(m_tick));
      chk("tick_ms", 32'(tick_ms), 32'(m_ms));
      chk("us_count", us_count, m_us);
      chk("busy", 32'(tif.tmr_busy), 32'(m_run));
      chk("expired", 32'(tif.tmr_expired), 32'(m_exp));
      chk("remaining", 32'(tif.tmr_remaining), m_rem);
   endtask

   int unsigned fmode = 0;
   int unsigned fcnt  = 0;

   function automatic logic next_freq(input logic cur);
      case (fmode)
         0:       return ~cur;
         1:       return logic'($urandom_range(0, 1));
         default: return ((fcnt % 6) < 3);
      endcase
   endfunction

   task automatic cyc(input bit ld, input int unsigned p, input bit per, input bit st);
      @(negedge clk);
      fcnt++;
      freq_in           = next_freq(freq_in);
      tif.tmr_load      = ld;
      tif.tmr_period    = TW'(p);
      tif.tmr_periodic  = per;
      tif.tmr_stop      = st;
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic idle(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) cyc(0, 0, 0, 0);
   endtask

   initial begin
      int unsigned guard;
      tif.tmr_load = 0; tif.tmr_period = '0; tif.tmr_periodic = 0; tif.tmr_stop = 0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_all();
      @(negedge clk);
      rst = 1'b0;

      // Toggling reference: tick every 2 clk, tick_ms every 4th tick.
      fmode = 0;
      idle(20);
      cyc(1, 3, 0, 0);   idle(12);         // one-shot
      cyc(1, 2, 1, 0);   idle(14);         // periodic
      cyc(0, 0, 0, 1);   idle(3);
      cyc(1, 0, 0, 0);   idle(3);          // zero period
      cyc(1, 5, 0, 1);   idle(3);          // stop beats load
      cyc(1, 9, 0, 0);
      guard = 0;
      while (!m_tick && guard < 10) begin idle(1); guard++; end
      if (guard >= 10) chk("wait_tick", 0, 1);
      cyc(1, 6, 1, 0);   idle(8);          // reload on a tick cycle
      cyc(0, 0, 0, 1);

      // Mid-run reset with remaining==5.
      cyc(1, 8, 1, 0);
      guard = 0;
      while (m_rem != 5 && guard < 40) begin idle(1); guard++; end
      if (guard >= 40) chk("wait_rem5", 0, 1);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("rst_tick_us", 32'(tick_us), 0);
      chk("rst_busy", 32'(tif.tmr_busy), 0);
      chk("rst_remaining", 32'(tif.tmr_remaining), 0);
      chk("rst_us_count", us_count, 0);
      model_reset();
      repeat (2) begin @(posedge clk); #1; check_all(); end
      @(negedge clk);
      rst = 1'b0;
      idle(20);

      // Randomized traffic across reference shapes.
      for (int unsigned blk = 0; blk < 15; blk++) begin
         fmode = $urandom_range(0, 2);
         for (int unsigned i = 0; i < 200; i++) begin
            bit ld, st, per;
            int unsigned p;
            ld  = ($urandom_range(0, 39) == 0);
            st  = ($urandom_range(0, 59) == 0);
            per = $urandom_range(0, 1);
            p   = m_run ? $urandom_range(1, 6) : $urandom_range(0, 6);
            cyc(ld, p, per, st);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
